// File: rtl/adc_rec_unpack_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_rec_unpack_if
// Description : Stream bundle shared by the ADC record unpacker and its
//               environment.
//               - Record stream: 128-bit words in_dat qualified by
//                 in_vld/in_rdy. The word moves on a clk edge where both
//                 are high.
//               - Sample stream: 16-bit smp_dat qualified by
//                 smp_vld/smp_rdy, with smp_last marking the final sample
//                 of a fill.
//               Modports:
//               - master : the environment. It supplies records and sinks
//                          samples.
//               - slave  : the unpacker.
// Revision    : 1.0  initial release
// ============================================================================
interface adc_rec_unpack_if;
    logic [127:0] in_dat;
    logic         in_vld;
    logic         in_rdy;
    logic [15:0]  smp_dat;
    logic         smp_vld;
    logic         smp_rdy;
    logic         smp_last;

    modport master (
        output in_dat, in_vld, smp_rdy,
        input  in_rdy, smp_dat, smp_vld, smp_last
    );

    modport slave (
        input  in_dat, in_vld, smp_rdy,
        output in_rdy, smp_dat, smp_vld, smp_last
    );
endinterface
`default_nettype wire

// File: rtl/adc_rec_unpack.sv
`default_nettype none
// ============================================================================
// Module      : adc_rec_unpack
// Description : Parses fill records read back from DDR3.
//               A fill consists of one header word, num_fill_bursts data
//               words and one checksum word. The checksum is the XOR of the
//               header and all data words.
//               Each data word carries eight 16-bit sign-extended ADC
//               samples. They are emitted lowest lane first on the sample
//               stream.
// Ports       : clk             - sole clock, rising edge
//               rst_n           - asynchronous active-low reset
//               bus             - record in / sample out streams (slave)
//               hdr_vld         - 1-cycle pulse, header fields updated
//               fill_num        - header [23:0]
//               burst_start_adr - header [57:35]
//               num_fill_bursts - header [84:64]
//               channel_tag     - header [111:96]
//               fill_type       - header [113:112]
//               fill_done       - 1-cycle pulse, checksum word consumed
//               cksum_ok        - checksum result, valid with fill_done
//               hdr_err         - 1-cycle pulse, header word rejected
//               ext_err_cnt     - saturating sign-extension violation count
// Revision    : 1.0  initial release
// ============================================================================
module adc_rec_unpack (
    input  wire logic               clk,
    input  wire logic               rst_n,
    adc_rec_unpack_if.slave         bus,
    output logic                    hdr_vld,
    output logic [23:0]             fill_num,
    output logic [22:0]             burst_start_adr,
    output logic [20:0]             num_fill_bursts,
    output logic [15:0]             channel_tag,
    output logic [1:0]              fill_type,
    output logic                    fill_done,
    output logic                    cksum_ok,
    output logic                    hdr_err,
    output logic [15:0]             ext_err_cnt
);

    localparam logic [1:0]  HDR_TAG     = 2'b01;
    localparam logic [2:0]  LAST_LANE   = 3'd7;
    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_DATA  = 2'd1,
        ST_CKSUM = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    // r_live rises on the first edge after reset release. It keeps in_rdy
    // low while reset is asserted.
    logic           r_live;

    // Serializer: one held data word plus the lane currently presented.
    logic [127:0]   r_word;
    logic           r_full;
    logic [2:0]     r_idx;
    logic           r_last_word;

    logic [20:0]    r_cnt;       // data words still to be accepted
    logic [127:0]   r_ck;        // running XOR checksum

    logic           w_in_rdy;
    logic           w_in_fire;
    logic           w_smp_fire;
    logic           w_smp_end;
    logic           w_hdr_ok;
    logic [15:0]    w_smp;
    logic           w_viol;

    // ------------------------------------------------------------------
    // Handshake and sample decode
    // ------------------------------------------------------------------
    assign w_hdr_ok   = (bus.in_dat[127:126] == HDR_TAG);
    assign w_smp      = r_word[{r_idx, 4'b0000} +: 16];
    assign w_viol     = (w_smp[15:12] != {4{w_smp[11]}});
    assign w_smp_fire = r_full & bus.smp_rdy;
    assign w_smp_end  = w_smp_fire & (r_idx == LAST_LANE);
    assign w_in_fire  = bus.in_vld & w_in_rdy;

    // in_rdy is a function of state, registered flags and smp_rdy only.
    // It never depends on in_vld.
    // In DATA a new word may land on the same edge that lane 7 leaves, so
    // back-to-back words flow without a bubble.
    // In CKSUM the checksum word waits until the last data word has fully
    // drained.
    always_comb begin
        w_in_rdy = 1'b0;
        case (r_state)
            ST_HDR:   w_in_rdy = r_live;
            ST_DATA:  w_in_rdy = ~r_full | w_smp_end;
            ST_CKSUM: w_in_rdy = ~r_full;
            default:  w_in_rdy = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HDR: begin
                if (w_in_fire && w_hdr_ok) begin
                    if (bus.in_dat[84:64] != 21'd0) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_CKSUM;
                    end
                end
            end
            ST_DATA: begin
                if (w_in_fire && (r_cnt == 21'd1)) begin
                    w_state_nxt = ST_CKSUM;
                end
            end
            ST_CKSUM: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_HDR;
                end
            end
            default: w_state_nxt = ST_HDR;
        endcase
    end

    // ------------------------------------------------------------------
    // Header capture, checksum, counter and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live          <= 1'b0;
            r_cnt           <= 21'd0;
            r_ck            <= 128'd0;
            hdr_vld         <= 1'b0;
            hdr_err         <= 1'b0;
            fill_done       <= 1'b0;
            cksum_ok        <= 1'b0;
            fill_num        <= 24'd0;
            burst_start_adr <= 23'd0;
            num_fill_bursts <= 21'd0;
            channel_tag     <= 16'd0;
            fill_type       <= 2'd0;
        end else begin
            r_live    <= 1'b1;
            hdr_vld   <= 1'b0;
            hdr_err   <= 1'b0;
            fill_done <= 1'b0;

            case (r_state)
                ST_HDR: begin
                    if (w_in_fire) begin
                        if (w_hdr_ok) begin
                            fill_num        <= bus.in_dat[23:0];
                            burst_start_adr <= bus.in_dat[57:35];
                            num_fill_bursts <= bus.in_dat[84:64];
                            channel_tag     <= bus.in_dat[111:96];
                            fill_type       <= bus.in_dat[113:112];
                            hdr_vld         <= 1'b1;
                            r_ck            <= bus.in_dat;
                            r_cnt           <= bus.in_dat[84:64];
                        end else begin
                            hdr_err <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_in_fire) begin
                        r_ck  <= r_ck ^ bus.in_dat;
                        r_cnt <= r_cnt - 21'd1;
                    end
                end
                ST_CKSUM: begin
                    if (w_in_fire) begin
                        fill_done <= 1'b1;
                        cksum_ok  <= (bus.in_dat == r_ck);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word      <= 128'd0;
            r_full      <= 1'b0;
            r_idx       <= 3'd0;
            r_last_word <= 1'b0;
        end else begin
            if ((r_state == ST_DATA) && w_in_fire) begin
                // A load also covers the case where lane 7 of the previous
                // word leaves on this same edge.
                r_word      <= bus.in_dat;
                r_full      <= 1'b1;
                r_idx       <= 3'd0;
                r_last_word <= (r_cnt == 21'd1);
            end else if (w_smp_fire) begin
                if (r_idx == LAST_LANE) begin
                    r_full <= 1'b0;
                    r_idx  <= 3'd0;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end
        end
    end

    // Violations are counted when the sample is handed over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_err_cnt <= 16'd0;
        end else if (w_smp_fire && w_viol && (ext_err_cnt != ERR_CNT_MAX)) begin
            ext_err_cnt <= ext_err_cnt + 16'd1;
        end
    end

    assign bus.in_rdy   = w_in_rdy;
    assign bus.smp_vld  = r_full;
    assign bus.smp_dat  = w_smp;
    assign bus.smp_last = r_full & r_last_word & (r_idx == LAST_LANE);

endmodule
`default_nettype wire

// File: tb/tb_adc_rec_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_rec_unpack
// Description : Directed self-checking bench for adc_rec_unpack.
//               Sends fills through the record stream.
//               A sink process consumes samples and counts status pulses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adc_rec_unpack;

    logic        clk;
    logic        rst_n;
    logic        hdr_vld;
    logic [23:0] fill_num;
    logic [22:0] burst_start_adr;
    logic [20:0] num_fill_bursts;
    logic [15:0] channel_tag;
    logic [1:0]  fill_type;
    logic        fill_done;
    logic        cksum_ok;
    logic        hdr_err;
    logic [15:0] ext_err_cnt;

    adc_rec_unpack_if bus();

    adc_rec_unpack dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .hdr_vld         (hdr_vld),
        .fill_num        (fill_num),
        .burst_start_adr (burst_start_adr),
        .num_fill_bursts (num_fill_bursts),
        .channel_tag     (channel_tag),
        .fill_type       (fill_type),
        .fill_done       (fill_done),
        .cksum_ok        (cksum_ok),
        .hdr_err         (hdr_err),
        .ext_err_cnt     (ext_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Sink / monitor state.
    bit          sink_rand = 1'b0;
    logic [16:0] q[$];        // {smp_last, smp_dat}
    int          hv_cnt = 0;
    int          fd_cnt = 0;
    int          he_cnt = 0;
    logic        last_ok = 1'b0;
    bit          stalled = 1'b0;
    logic [15:0] held_dat = 16'd0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // smp_rdy changes at the falling edge.
    // One time unit later the handshake that completes at the next rising
    // edge is known and recorded.
    always @(negedge clk) begin
        bus.smp_rdy = sink_rand ? ($urandom_range(0, 1) != 0) : 1'b1;
        #1;
        if (rst_n) begin
            if (stalled) begin
                chk("stall_vld", bus.smp_vld, 1'b1);
                chk("stall_dat", bus.smp_dat, held_dat);
            end
            if (bus.smp_vld && bus.smp_rdy) q.push_back({bus.smp_last, bus.smp_dat});
            stalled  = bus.smp_vld && !bus.smp_rdy;
            held_dat = bus.smp_dat;
            if (hdr_vld) hv_cnt++;
            if (hdr_err) he_cnt++;
            if (fill_done) begin
                fd_cnt++;
                last_ok = cksum_ok;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    function automatic logic [127:0] mk_hdr(input logic [1:0] t, input logic [23:0] f,
                                             input logic [22:0] a, input logic [20:0] n,
                                             input logic [15:0] c, input logic [1:0] ft);
        return {t, 12'h000, ft, c, 11'h000, n, 6'h00, a, 11'h000, f};
    endfunction

    task automatic send_word(input logic [127:0] w);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        bus.in_dat = w;
        bus.in_vld = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            #2;
            if (bus.in_rdy) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        #1;
        bus.in_vld = 1'b0;
        chk("send_accept", ok, 1'b1);
    endtask

    task automatic wait_fill(input int target);
        for (int i = 0; i < 600 && fd_cnt < target; i++) @(negedge clk);
        #3;
        chk("fill_done_seen", fd_cnt, target);
    endtask

    task automatic wait_samples(input int n);
        for (int i = 0; i < 300 && q.size() < n; i++) begin
            @(negedge clk);
            #3;
        end
        chk("samples_seen", (q.size() >= n), 1'b1);
    endtask

    task automatic chk_samples(input string tag, input logic [7:0][15:0] a, input logic [7:0][15:0] b);
        logic [16:0] exp;
        logic [16:0] got;
        chk({tag, "_count"}, q.size(), 16);
        for (int k = 0; k < 16; k++) begin
            exp = {(k == 15), (k < 8) ? a[k] : b[k - 8]};
            got = (k < q.size()) ? q[k] : 17'h1FFFF;
            chk($sformatf("%s_smp%0d", tag, k), got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_rdy"},   bus.in_rdy,      1'b0);
        chk({tag, "_smp_vld"},  bus.smp_vld,     1'b0);
        chk({tag, "_smp_last"}, bus.smp_last,    1'b0);
        chk({tag, "_smp_dat"},  bus.smp_dat,     16'h0);
        chk({tag, "_hdr_vld"},  hdr_vld,         1'b0);
        chk({tag, "_fill_done"},fill_done,       1'b0);
        chk({tag, "_cksum_ok"}, cksum_ok,        1'b0);
        chk({tag, "_hdr_err"},  hdr_err,         1'b0);
        chk({tag, "_fields"},   {fill_num, burst_start_adr, num_fill_bursts, channel_tag, fill_type}, 86'h0);
        chk({tag, "_ext_err"},  ext_err_cnt,     16'h0);
    endtask

    logic [127:0]     h1, h4, h5, bad_h;
    logic [7:0][15:0] d0, d1, d2, d3;

    initial begin
        bus.in_dat  = '0;
        bus.in_vld  = 1'b0;
        bus.smp_rdy = 1'b1;
        rst_n       = 1'b0;

        h1    = mk_hdr(2'b01, 24'h000123, 23'h000010, 21'd2, 16'hA5A5, 2'b10);
        h4    = mk_hdr(2'b01, 24'h000456, 23'h7FFFFF, 21'd0, 16'h5A5A, 2'b01);
        h5    = mk_hdr(2'b01, 24'h000789, 23'h000020, 21'd2, 16'h1111, 2'b00);
        bad_h = mk_hdr(2'b11, 24'hFFFFFF, 23'h000001, 21'd1, 16'hDEAD, 2'b11);
        d0 = {16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
        d1 = {16'h000F, 16'h000E, 16'h000D, 16'h000C, 16'h000B, 16'h000A, 16'h0009, 16'h0008};
        d2 = {16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0800, 16'h0002, 16'h0001, 16'hFFFF};
        d3 = {16'hF800, 16'h07FF, 16'h0123, 16'hFEDC, 16'h0000, 16'hFFF0, 16'h0011, 16'h0022};

        // Reset state, and in_rdy rising on the first edge after release.
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_rdy_before_edge", bus.in_rdy, 1'b0);
        @(posedge clk);
        #1;
        chk("in_rdy_after_edge", bus.in_rdy, 1'b1);

        // Nominal two-burst fill.
        send_word(h1);
        send_word(d0);
        send_word(d1);
        send_word(h1 ^ d0 ^ d1);
        wait_fill(1);
        chk("t1_cksum_ok", last_ok, 1'b1);
        chk("t1_hdr_vld_cnt", hv_cnt, 1);
        chk("t1_fill_num", fill_num, 24'h000123);
        chk("t1_adr", burst_start_adr, 23'h000010);
        chk("t1_bursts", num_fill_bursts, 21'd2);
        chk("t1_tag", channel_tag, 16'hA5A5);
        chk("t1_type", fill_type, 2'b10);
        chk_samples("t1", d0, d1);
        chk("t1_ext_err", ext_err_cnt, 16'd0);
        q.delete();

        // Corrupted checksum.
        send_word(h1);
        send_word(d0);
        send_word(d1);
        send_word(h1 ^ d0 ^ d1 ^ 128'd1);
        wait_fill(2);
        chk("t2_cksum_ok", last_ok, 1'b0);
        chk_samples("t2", d0, d1);
        q.delete();

        // Rejected header, then a zero-burst fill.
        send_word(bad_h);
        @(negedge clk);
        #3;
        chk("t3_hdr_err_cnt", he_cnt, 1);
        chk("t3_hdr_vld_cnt", hv_cnt, 2);
        chk("t3_fields_kept", fill_num, 24'h000123);
        send_word(h4);
        send_word(h4);
        wait_fill(3);
        chk("t4_cksum_ok", last_ok, 1'b1);
        chk("t4_hdr_vld_cnt", hv_cnt, 3);
        chk("t4_no_samples", q.size(), 0);
        chk("t4_adr", burst_start_adr, 23'h7FFFFF);
        chk("t4_tag", channel_tag, 16'h5A5A);
        chk("t4_type", fill_type, 2'b01);
        chk("t4_bursts", num_fill_bursts, 21'd0);

        // Sign-extension violation with random sink stalls.
        sink_rand = 1'b1;
        send_word(h5);
        send_word(d2);
        send_word(d3);
        send_word(h5 ^ d2 ^ d3);
        wait_fill(4);
        chk("t5_cksum_ok", last_ok, 1'b1);
        chk_samples("t5", d2, d3);
        chk("t5_ext_err", ext_err_cnt, 16'd1);
        sink_rand = 1'b0;
        q.delete();

        // Reset in the middle of a fill.
        send_word(h1);
        send_word(d0);
        wait_samples(5);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        send_word(h1);
        send_word(d0);
        send_word(d1);
        send_word(h1 ^ d0 ^ d1);
        wait_fill(5);
        chk("t6_cksum_ok", last_ok, 1'b1);
        chk("t6_fill_num", fill_num, 24'h000123);
        chk_samples("t6", d0, d1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_rec_unpack.md
ADC_REC_UNPACK -- requirements
Module: adc_rec_unpack

Interface
REQ-001 clk  in  1  sole clock; all state on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 in_dat  in  128  record word from DDR3 read FIFO.
REQ-004 in_vld / in_rdy  in / out  1 / 1  word transfer when both high on a clk edge.
REQ-005 hdr_vld  out  1  one-cycle pulse; header fields below are valid and held until the next header.
REQ-006 fill_num  out  24  header bits [23:0].
REQ-007 burst_start_adr  out  23  header bits [57:35].
REQ-008 num_fill_bursts  out  21  header bits [84:64].
REQ-009 channel_tag  out  16  header bits [111:96].
REQ-010 fill_type  out  2  header bits [113:112].
REQ-011 smp_dat  out  16  one sign-extended ADC sample.
REQ-012 smp_vld / smp_rdy  out / in  1 / 1  sample transfer when both high.
REQ-013 smp_last  out  1  high with the final sample of a fill.
REQ-014 fill_done  out  1  one-cycle pulse when the checksum word is consumed.
REQ-015 cksum_ok  out  1  valid during fill_done; 1 = checksum matched.
REQ-016 hdr_err  out  1  one-cycle pulse on rejected header word.
REQ-017 ext_err_cnt  out  16  saturating count of sign-extension violations.

Function
REQ-018 States: HDR, DATA, CKSUM; reset state HDR.
REQ-019 HDR: in_rdy=1. Accepted word with bits[127:126]==2'b01 -> latch fields, pulse hdr_vld, init checksum = word, load remaining-word counter = bits[84:64].
REQ-020 HDR, tag != 2'b01: drop word, pulse hdr_err, stay in HDR; fields unchanged.
REQ-021 HDR -> DATA if num_fill_bursts != 0; else HDR -> CKSUM.
REQ-022 DATA: each accepted word is one 8-sample burst; XOR into checksum; decrement counter.
REQ-023 Sample k (k=0..7) = word[16k+15:16k]; emitted k=0 (oldest) first, one per smp handshake.
REQ-024 Violation when word[16k+15:16k+12] != {4{word[16k+11]}}; checked at emission; ext_err_cnt +1, saturating at 16'hFFFF; sample still emitted unchanged.
REQ-025 Serializer holds one 128-bit word plus a 3-bit index; in_rdy in DATA = (holding empty) OR (index==7 AND smp_vld AND smp_rdy) -- back-to-back words, no bubble.
REQ-026 smp_vld is 1 while holding is full; smp_dat and smp_vld stable while smp_rdy=0.
REQ-027 smp_last = 1 for index 7 of the last data word only.
REQ-028 DATA -> CKSUM once the last data word is accepted; in_rdy stays 0 until that word's sample 7 is accepted.
REQ-029 CKSUM: in_rdy=1; on accept, cksum_ok = (word == running checksum), pulse fill_done, -> HDR.
REQ-030 Counter width 21 bits; num_fill_bursts=21'h1FFFFF handled without overflow.
REQ-031 No combinational path from in_vld to in_rdy or from smp_rdy to smp_vld; smp_rdy -> in_rdy path permitted (REQ-025).
REQ-032 Latency: first sample smp_vld asserted cycle after the data-word accept edge.

Reset
REQ-033 rst_n low, any state incl. mid-fill: immediate clear; state=HDR, holding empty, index=0, counter=0, checksum=0.
REQ-034 Outputs during reset: in_rdy=0, smp_vld=0, smp_last=0, hdr_vld=0, fill_done=0, cksum_ok=0, hdr_err=0, smp_dat=0, all header fields=0, ext_err_cnt=0.
REQ-035 in_rdy=1 from the first clk edge after rst_n deasserts.

Verification
REQ-036 Header H (tag 01, fill_num 24'h000123, adr 23'h000010, bursts 2, tag 16'hA5A5, type 2'b10), data D0, D1, checksum H^D0^D1, smp_rdy=1 -> 16 samples in order, smp_last on 16th only, fill_done with cksum_ok=1.
REQ-037 Same stream, checksum bit 0 flipped -> fill_done with cksum_ok=0; next header accepted normally.
REQ-038 Header with bits[127:126]=2'b11 -> hdr_err pulse, no hdr_vld, next valid header accepted.
REQ-039 num_fill_bursts=0 -> header then checksum==header -> fill_done, cksum_ok=1, no samples.
REQ-040 Data word sample 3 = 16'h0800 (bit11=1, ext 0) -> ext_err_cnt 0->1, smp_dat=16'h0800 emitted; random smp_rdy stalls -> no sample lost or duplicated.
REQ-041 rst_n pulsed low after 5 of 16 samples -> all outputs at reset values; new fill afterwards parsed correctly.
